// File: rtl/fpdlink_serdes_out.sv
// fpdlink_serdes_out: FPD-Link I 7:1 LVDS transmitter with valid/ready input FIFO.
// Define FPDLINK_TX_HOLD_EN to re-send the last popped word on underflow instead of all-zero.
module fpdlink_serdes_out #(
    parameter int               LANES      = 6,
    parameter logic             CLK_INVERT = 1'b0,
    parameter logic [LANES-1:0] CH_INVERT  = '0,
    parameter int               FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [LANES*7-1:0] din,
    input  logic               din_valid,
    output logic               din_ready,
    output logic [LANES-1:0]   dout,
    output logic               cout,
    output logic               slot0,
    output logic               underflow
);
    localparam int W = LANES * 7;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [6:0] PATTERN = 7'b1100011;

    logic [2:0]    s_q, s_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  mem_q [FIFO_DEPTH];
    logic [W-1:0]  shreg_q, shreg_d, idle_word;
    logic [1:0]    rsync_q;
    logic          din_ready_q, din_ready_d;
    logic          cout_q, cout_d;
    logic          slot0_q, slot0_d;
    logic          underflow_q, underflow_d;
    logic          push, load, pop;

    // slot sequencing, FIFO bookkeeping and shift-register load/shift
    always_comb begin
        push        = din_valid & din_ready_q;
        load        = s_q == 3'd6;
        pop         = load & (count_q != '0);
        s_d         = load ? 3'd0 : s_q + 3'd1;
        wr_ptr_d    = wr_ptr_q + AW'(push);
        rd_ptr_d    = rd_ptr_q + AW'(pop);
        count_d     = count_q + CW'(push) - CW'(pop);
        din_ready_d = rsync_q[1] & (count_d != CW'(FIFO_DEPTH));
        shreg_d     = load ? (pop ? mem_q[rd_ptr_q] : idle_word) : shreg_q << 1;
        cout_d      = PATTERN[3'd6 - s_d] ^ CLK_INVERT;
        slot0_d     = load;
        underflow_d = load & ~pop;
    end

`ifdef FPDLINK_TX_HOLD_EN
    logic [W-1:0] last_q, last_d;

    // track the last popped word so an underflow repeats the previous pixel
    always_comb last_d = pop ? mem_q[rd_ptr_q] : last_q;

    // last-word register, cleared to black on reset
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) last_q <= '0;
        else last_q <= last_d;

    assign idle_word = last_q;
`else
    assign idle_word = '0;
`endif

    // two-flop synchroniser on reset release, gating din_ready only
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) rsync_q <= '0;
        else rsync_q <= {rsync_q[0], 1'b1};

    // control and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_q         <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            shreg_q     <= '0;
            din_ready_q <= 1'b0;
            cout_q      <= CLK_INVERT ^ 1'b1;
            slot0_q     <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            s_q         <= s_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            shreg_q     <= shreg_d;
            din_ready_q <= din_ready_d;
            cout_q      <= cout_d;
            slot0_q     <= slot0_d;
            underflow_q <= underflow_d;
        end
    end

    // FIFO storage; validity is defined by the pointers, so no reset needed
    always_ff @(posedge clk)
        if (push) mem_q[wr_ptr_q] <= din;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign dout[i] = shreg_q[(LANES-1-i)*7+6] ^ CH_INVERT[i];
    end

    assign din_ready = din_ready_q;
    assign cout      = cout_q;
    assign slot0     = slot0_q;
    assign underflow = underflow_q;
endmodule

// File: tb/tb_fpdlink_serdes_out.sv
// tb_fpdlink_serdes_out: scoreboard bench; a monitor deserialises the lanes and checks against queued pushes.
module tb_fpdlink_serdes_out;
    localparam int LANES = 6;
    localparam logic CI = 1'b1;
    localparam logic [LANES-1:0] CHI = 6'b000101;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [LANES*7-1:0] din = '0;
    logic              din_valid = 1'b0;
    logic              din_ready;
    logic [LANES-1:0]  dout;
    logic              cout, slot0, underflow;

    fpdlink_serdes_out #(.LANES(LANES), .CLK_INVERT(CI), .CH_INVERT(CHI), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rstn(rstn), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .dout(dout), .cout(cout), .slot0(slot0), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [41:0] w;
        int          c;
    } ent_t;

    ent_t        q[$];
    int          cyc;
    int          vecs = 0;
    int          errs = 0;
    logic [41:0] last = '0;
    logic [41:0] cur_exp = '0;
    logic [6:0]  rx [LANES];
    logic [6:0]  pat = 7'b1100011;

    // cycle index since reset release; slot s = cyc % 7 during that cycle
    always @(posedge clk or negedge rstn)
        if (!rstn) cyc <= 0;
        else cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // monitor: checks clock lane, slot timing, ready status and recovered words
    always @(negedge clk) begin
        int s;
        int n;
        logic [41:0] word;
        if (rstn) begin
            s = cyc % 7;
            chk("cout", 64'(cout), 64'(pat[6-s] ^ CI));
            chk("slot0", 64'(slot0), 64'(cyc >= 7 && s == 0));
            if (cyc >= 7 && s == 0) begin
                if (q.size() > 0 && q[0].c <= cyc - 2) begin
                    cur_exp = q[0].w;
                    last = cur_exp;
                    void'(q.pop_front());
                    chk("underflow", 64'(underflow), 64'(0));
                end else begin
`ifdef FPDLINK_TX_HOLD_EN
                    cur_exp = last;
`else
                    cur_exp = '0;
`endif
                    chk("underflow", 64'(underflow), 64'(1));
                end
            end else
                chk("underflow", 64'(underflow), 64'(0));
            if (cyc >= 7)
                for (int i = 0; i < LANES; i++) rx[i][6-s] = dout[i] ^ CHI[i];
            if (cyc >= 7 && s == 6) begin
                for (int i = 0; i < LANES; i++) word[(LANES-1-i)*7 +: 7] = rx[i];
                chk("word", 64'(word), 64'(cur_exp));
            end
            n = 0;
            foreach (q[k]) if (q[k].c < cyc) n++;
            chk("din_ready", 64'(din_ready), 64'(cyc >= 3 && n != 4));
        end
    end

    task automatic push_word(input logic [41:0] w);
        din = w;
        din_valid = 1'b1;
        for (int n = 0; n < 60; n++) begin
            if (din_ready) begin
                q.push_back('{w, cyc});
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        chk("push_accept", 64'(0), 64'(1));
    endtask

    task automatic drain();
        for (int n = 0; n < 400; n++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", 64'(q.size()), 64'(0));
        repeat (8) @(negedge clk);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_dout", 64'(dout), 64'(CHI));
        chk("rst_cout", 64'(cout), 64'(CI ^ 1'b1));
        chk("rst_slot0", 64'(slot0), 64'(0));
        chk("rst_underflow", 64'(underflow), 64'(0));
        chk("rst_din_ready", 64'(din_ready), 64'(0));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 chk_reset_outputs();
        @(posedge clk);
        #2 rstn = 1'b1;
        repeat (28) @(negedge clk);
        push_word({7'b1011001, 35'b0});
        din_valid = 1'b0;
        repeat (12) @(negedge clk);
        for (int k = 0; k < 16; k++)
            push_word(42'h155_5555_5555 + 42'(k) * 42'h041_0410_4104);
        din_valid = 1'b0;
        drain();
        push_word(42'h2AA_AAAA_AAAA);
        din_valid = 1'b0;
        repeat (30) @(negedge clk);
        for (int k = 0; k < 5; k++)
            push_word(42'h0F0_F0F0_F0F0 ^ 42'(k));
        din_valid = 1'b0;
        @(posedge clk);
        #2 rstn = 1'b0;
        #1 chk_reset_outputs();
        q.delete();
        last = '0;
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        push_word(42'h3FF_FFFF_FFFF);
        push_word(42'h000_0000_007F);
        din_valid = 1'b0;
        drain();
        repeat (10) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
